// File: rtl/io_pkg.sv
// Shared store-path types and the byte-lane merge used by output_buffer and other store paths.
// Pure definitions: no state, no latency.
// No flow control.
package io_pkg;

    localparam logic [2:0] ST_BYTE = 3'b000;
    localparam logic [2:0] ST_HALF = 3'b001;
    localparam logic [2:0] ST_WORD = 3'b010;

    // Codes other than byte/half behave as a full word so unknown funct3 never loses data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] shadow,
        input logic [31:0] data,
        input logic [2:0]  store_type,
        input logic [1:0]  offset
    );
        logic [31:0] merged;
        merged = shadow;
        case (store_type)
            ST_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = data[7:0];
                    2'd1:    merged[15:8]  = data[7:0];
                    2'd2:    merged[23:16] = data[7:0];
                    default: merged[31:24] = data[7:0];
                endcase
            end
            ST_HALF: begin
                if (offset[1]) merged[31:16] = data[15:0];
                else           merged[15:0]  = data[15:0];
            end
            default: merged = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with count-based full/empty decode.
// Push data visible at head one cycle after push into an empty FIFO.
// Push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage is deliberately not reset; consumers mask the head with empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_buffer.sv
// CPU store path to IO: merges sub-word stores into a shadow word and queues each merged word.
// Accepted store appears on io_out one edge later when the queue was empty; no bypass.
// Stores while full are dropped and flag sticky overflow; io_ready pops the head.
module output_buffer
    import io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write,
    input  logic [2:0]  data_type,
    input  logic [1:0]  data_offset,
    input  logic [31:0] cpu_in,
    output logic [31:0] io_out,
    output logic        io_valid,
    input  logic        io_ready,
    output logic        full,
    output logic        overflow,
    output logic [31:0] shadow
);

    logic        accept;
    logic        empty;
    logic [31:0] merged;
    logic [31:0] head;

    // Acceptance looks only at registered full, so a same-cycle pop cannot make room.
    assign accept   = write && !full;
    assign merged   = merge_store(shadow, cpu_in, data_type, data_offset);
    assign io_valid = !empty;
    assign io_out   = io_valid ? head : 32'h0;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (accept),
        .push_dat (merged),
        .pop      (io_ready),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow   <= 32'h0;
            overflow <= 1'b0;
        end else begin
            if (accept)          shadow   <= merged;
            if (write && full)   overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
module tb_output_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  data_type;
    logic [1:0]  data_offset;
    logic [31:0] cpu_in;
    logic [31:0] io_out;
    logic        io_valid;
    logic        io_ready;
    logic        full;
    logic        overflow;
    logic [31:0] shadow;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    output_buffer #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .write       (write),
        .data_type   (data_type),
        .data_offset (data_offset),
        .cpu_in      (cpu_in),
        .io_out      (io_out),
        .io_valid    (io_valid),
        .io_ready    (io_ready),
        .full        (full),
        .overflow    (overflow),
        .shadow      (shadow)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_store(input logic w, input logic [2:0] t, input logic [1:0] o, input logic [31:0] d);
        write       = w;
        data_type   = t;
        data_offset = o;
        cpu_in      = d;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        io_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (shadow !== 32'h0) begin failures++; $display("FAIL reset_shadow got=%h exp=%h", shadow, 32'h0); end
        checks++;
        if (io_valid !== 1'b0 || io_out !== 32'h0) begin failures++; $display("FAIL reset_io got=%b/%h exp=0/0", io_valid, io_out); end
        checks++;
        if (full !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", full, overflow); end
    endtask

    task automatic test_word_store();
        set_store(1'b1, 3'b010, 2'd0, 32'hDEADBEEF);
        tick();
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        checks++;
        if (io_valid !== 1'b1 || io_out !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_io got=%b/%h exp=1/deadbeef", io_valid, io_out); end
        checks++;
        if (shadow !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_shadow got=%h exp=deadbeef", shadow); end
        io_ready = 1'b1;
        tick();
        checks++;
        if (io_valid !== 1'b0 || io_out !== 32'h0) begin failures++; $display("FAIL sw_drain got=%b/%h exp=0/0", io_valid, io_out); end
    endtask

    task automatic test_merge();
        io_ready = 1'b1;
        set_store(1'b1, 3'b000, 2'd2, 32'hFFFFFF11);
        tick();
        checks++;
        if (io_out !== 32'hDE11BEEF || shadow !== 32'hDE11BEEF) begin failures++; $display("FAIL merge_sb got=%h/%h exp=de11beef", io_out, shadow); end
        set_store(1'b1, 3'b001, 2'd3, 32'hFFFF2233);
        tick();
        checks++;
        if (io_out !== 32'h2233BEEF || shadow !== 32'h2233BEEF) begin failures++; $display("FAIL merge_sh_hi got=%h/%h exp=2233beef", io_out, shadow); end
        set_store(1'b1, 3'b001, 2'd1, 32'h0000CAFE);
        tick();
        checks++;
        if (io_out !== 32'h2233CAFE) begin failures++; $display("FAIL merge_sh_lo got=%h exp=2233cafe", io_out); end
        set_store(1'b1, 3'b000, 2'd0, 32'h00000055);
        tick();
        checks++;
        if (io_out !== 32'h2233CA55) begin failures++; $display("FAIL merge_sb0 got=%h exp=2233ca55", io_out); end
        set_store(1'b1, 3'b111, 2'd3, 32'h12345678);
        tick();
        checks++;
        if (io_out !== 32'h12345678 || shadow !== 32'h12345678) begin failures++; $display("FAIL merge_other got=%h/%h exp=12345678", io_out, shadow); end
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        tick();
        checks++;
        if (io_valid !== 1'b0) begin failures++; $display("FAIL merge_empty got=%b exp=0", io_valid); end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            set_store(1'b1, 3'b010, 2'd0, 32'(i));
            tick();
            checks++;
            if (full !== (i == 4)) begin failures++; $display("FAIL fill_full_%0d got=%b exp=%b", i, full, (i == 4)); end
        end
        set_store(1'b1, 3'b010, 2'd0, 32'd5);
        tick();
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        checks++;
        if (overflow !== 1'b1 || shadow !== 32'd4 || full !== 1'b1) begin
            failures++; $display("FAIL drop5 got=ovf%b sh%h full%b exp=1/4/1", overflow, shadow, full);
        end
        io_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (io_valid !== 1'b1 || io_out !== 32'(i)) begin failures++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, io_valid, io_out, 32'(i)); end
            tick();
            if (i == 1) begin
                checks++;
                if (full !== 1'b0) begin failures++; $display("FAIL full_fall got=%b exp=0", full); end
            end
        end
        checks++;
        if (io_valid !== 1'b0 || io_out !== 32'h0 || overflow !== 1'b1) begin
            failures++; $display("FAIL drained got=%b/%h ovf%b exp=0/0/1", io_valid, io_out, overflow);
        end
    endtask

    task automatic test_full_pop_same();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 3'b010, 2'd0, 32'hA0 + 32'(i));
            tick();
        end
        io_ready = 1'b1;
        set_store(1'b1, 3'b010, 2'd0, 32'hFF);
        tick();
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        io_ready = 1'b0;
        checks++;
        if (overflow !== 1'b1 || full !== 1'b0 || shadow !== 32'hA3) begin
            failures++; $display("FAIL fullpop got=ovf%b full%b sh%h exp=1/0/a3", overflow, full, shadow);
        end
        io_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (io_out !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL fullpop_drain_%0d got=%h exp=%h", i, io_out, 32'hA0 + 32'(i)); end
            tick();
        end
        checks++;
        if (io_valid !== 1'b0) begin failures++; $display("FAIL fullpop_empty got=%b exp=0", io_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        io_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_store(1'b1, 3'b010, 2'd0, 32'h100 + 32'(i));
            tick();
            checks++;
            if (io_valid !== 1'b1 || io_out !== 32'h100 + 32'(i) || full !== 1'b0) begin
                failures++; $display("FAIL stream_%0d got=%b/%h full%b exp=1/%h/0", i, io_valid, io_out, full, 32'h100 + 32'(i));
            end
        end
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        tick();
        checks++;
        if (io_valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL stream_end got=%b ovf%b exp=0/0", io_valid, overflow); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        set_store(1'b1, 3'b010, 2'd0, 32'h11);
        tick();
        set_store(1'b1, 3'b010, 2'd0, 32'h22);
        tick();
        reset = 1'b1;
        set_store(1'b1, 3'b010, 2'd0, 32'h77);
        io_ready = 1'b1;
        tick();
        reset = 1'b0;
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        io_ready = 1'b0;
        checks++;
        if (io_valid !== 1'b0 || io_out !== 32'h0 || shadow !== 32'h0 || full !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL midreset got=%b/%h sh%h full%b ovf%b exp=all0", io_valid, io_out, shadow, full, overflow);
        end
        tick();
        checks++;
        if (io_valid !== 1'b0) begin failures++; $display("FAIL midreset_hold got=%b exp=0", io_valid); end
    endtask

    initial begin
        reset    = 1'b1;
        io_ready = 1'b0;
        set_store(1'b0, 3'b010, 2'd0, 32'h0);
        test_reset();
        test_word_store();
        test_merge();
        test_full_overflow();
        test_full_pop_same();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
# output_buffer

CPU-to-IO store path for memory-mapped output. It merges byte, halfword and word stores into a 32-bit shadow word, then queues each merged word in a small FIFO. An IO-side consumer drains that FIFO through a valid/ready handshake. It sits between the load/store unit's store decode and the external output pins, and is the write-side counterpart of the IO input register.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- write  input  1  CPU store strobe, one store per cycle high
- data_type  input  3  store width code (funct3): 000 byte, 001 halfword, 010 word
- data_offset  input  2  byte address offset within the word
- cpu_in  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- io_out  output  32  FIFO head word
- io_valid  output  1  FIFO non-empty
- io_ready  input  1  consumer accepts head this cycle
- full  output  1  FIFO holds DEPTH entries; CPU must stall stores
- overflow  output  1  sticky: a store was dropped because FIFO was full
- shadow  output  32  current merged shadow word, for CPU readback

## Operation
- Accept: write && !full. Acceptance depends only on the registered full, so a write while full is dropped even if a pop occurs the same cycle. A dropped write sets overflow; only reset clears overflow.
- Merge on accept: new = shadow with lanes replaced.
  - Byte: cpu_in[7:0] into byte lane data_offset.
  - Halfword: cpu_in[15:0] into lanes {data_offset[1],0} and {data_offset[1],1}. data_offset[0] is ignored, so misaligned halfwords round down.
  - Word and every other data_type code: full cpu_in, offset ignored.
- On accept: shadow <= new, and new is pushed at the FIFO tail. The pushed value is the merged word, not raw cpu_in.
- Dropped write: shadow unchanged, nothing pushed.
- Pop: io_valid && io_ready advances the read pointer. io_ready with io_valid low has no effect.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. The count is clog2(DEPTH)+1 bits wide, so that full and empty are distinguishable.
- io_out = 32'h0 whenever io_valid is low; otherwise it is the head entry.

## Timing
- Reset values: shadow 0, io_out 0, io_valid 0, full 0, overflow 0, pointers and count 0. FIFO storage is not cleared, but it is masked by io_valid.
- Reset has priority over write and io_ready in the same cycle. A reset mid-stream discards all queued entries.
- Write latency: a store accepted at edge N appears on io_out/io_valid after edge N, provided the FIFO was empty. There is no combinational bypass from cpu_in to io_out.
- shadow reflects an accepted store after the same edge N.
- full and io_valid are registered-state decodes of count. full rises after the edge that makes count = DEPTH; it falls after the first pop from full.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package io_pkg:
  - store_type constants ST_BYTE=3'b000, ST_HALF=3'b001, ST_WORD=3'b010
  - lane-merge function merge_store(shadow, data, type, offset), reusable by other store paths
- Sub-module sync_fifo (parameters WIDTH, DEPTH) owns the storage, pointers, count, full and empty. output_buffer holds the shadow register, merge logic, acceptance/overflow logic and io_out masking.

## Test plan
- Reset, then SW 0xDEADBEEF with io_ready=0 → after one edge io_valid=1, io_out=0xDEADBEEF, shadow=0xDEADBEEF.
- From shadow 0xDEADBEEF: SB 0x11 at offset 2, then SH 0x2233 at offset 3, io_ready=1 → queued words 0xDE11BEEF then 0x2233BEEF, popped in that order.
- DEPTH=4, io_ready=0, five SW stores 1..5 → full=1 after the fourth; fifth dropped; overflow=1; shadow=4; drain yields 1,2,3,4, then io_valid=0 and io_out=0.
- Full FIFO with write and io_ready both high in the same cycle → write dropped, overflow set, one pop, full=0 next cycle.
- Steady stream of SW stores with io_ready=1 → one word per cycle, count stays ≤1, no overflow; pointer wrap-around checked over 3×DEPTH stores.
- reset asserted with two entries queued and write=1 → next cycle all outputs at reset values, write ignored.
